// File: rtl/cyclic_encoder_7_4_pkg.sv
`default_nettype none
// ============================================================================
// cyclic_encoder_7_4_pkg : shared constants and state encoding, (7,4) encoder
// Revision: 1.0
// ============================================================================
package cyclic_encoder_7_4_pkg;
    localparam int N = 7;
    localparam int K = 4;
    localparam logic [2:0] DEFAULT_GEN = 3'b011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MSG  = 2'd1,
        ST_PAR  = 2'd2
    } state_t;
endpackage
`default_nettype wire

// File: rtl/cyclic_encoder_7_4_lfsr.sv
`default_nettype none
// ============================================================================
// parity_lfsr_3 : 3-bit division LFSR; absorbs message bits, then shifts out
// Revision: 1.0
// ============================================================================
module parity_lfsr_3 (
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       shift_in_en,
    input  logic       shift_out_en,
    input  logic       din,
    input  logic [2:0] gen,
    output logic       dout
);
    logic [2:0] par_q;
    logic       fb;

    assign fb   = din ^ par_q[2];
    assign dout = par_q[2];

    always_ff @(posedge clk) begin
        if (!reset || clear) begin
            par_q <= '0;
        end else if (shift_in_en) begin
            par_q <= {par_q[1] ^ (gen[2] & fb),
                      par_q[0] ^ (gen[1] & fb),
                      gen[0] & fb};
        end else if (shift_out_en) begin
            // remainder leaves MSB first; no feedback once the message is consumed
            par_q <= {par_q[1:0], 1'b0};
        end
    end
endmodule
`default_nettype wire

// File: rtl/cyclic_encoder_7_4.sv
`default_nettype none
// ============================================================================
// cyclic_encoder_7_4 : systematic serial (7,4) cyclic encoder, c6 first
// Revision: 1.0
// ============================================================================
module cyclic_encoder_7_4
    import cyclic_encoder_7_4_pkg::*;
#(
    parameter logic [2:0] GEN = DEFAULT_GEN
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [3:0] msg_in,
    output logic       code_bit,
    output logic       code_valid,
    output logic       busy,
    output logic       done,
    output logic [6:0] codeword
);
    localparam logic [2:0] LAST_MSG = 3'(K - 1);
    localparam logic [2:0] LAST_BIT = 3'(N - 1);

    state_t     state_q;
    logic [2:0] cnt_q;
    logic [3:0] msg_q;
    logic       valid_q;
    logic       done_q;
    logic [5:0] hist_q;
    logic [6:0] codeword_q;

    logic       last_bit;
    logic       accept;
    logic [1:0] msg_idx;
    logic       lfsr_dout;

    assign last_bit = (state_q == ST_PAR) && (cnt_q == LAST_BIT);
    assign accept   = start && ((state_q == ST_IDLE) || last_bit);
    assign msg_idx  = 2'd3 - cnt_q[1:0];

    parity_lfsr_3 u_lfsr (
        .clk          (clk),
        .reset        (reset),
        .clear        (accept),
        .shift_in_en  (state_q == ST_MSG),
        .shift_out_en (state_q == ST_PAR),
        .din          (msg_q[msg_idx]),
        .gen          (GEN),
        .dout         (lfsr_dout)
    );

    always_comb begin
        code_bit = 1'b0;
        case (state_q)
            ST_MSG:  code_bit = msg_q[msg_idx];
            ST_PAR:  code_bit = lfsr_dout;
            default: code_bit = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            msg_q      <= '0;
            valid_q    <= 1'b0;
            done_q     <= 1'b0;
            hist_q     <= '0;
            codeword_q <= '0;
        end else begin
            done_q <= 1'b0;
            if (valid_q) begin
                hist_q <= {hist_q[4:0], code_bit};
            end
            // hist_q holds c6..c1 while c0 is on the line
            if (done_q) begin
                codeword_q <= {hist_q, code_bit};
            end
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        msg_q   <= msg_in;
                        cnt_q   <= '0;
                        valid_q <= 1'b1;
                        state_q <= ST_MSG;
                    end
                end
                ST_MSG: begin
                    cnt_q <= cnt_q + 3'd1;
                    if (cnt_q == LAST_MSG) begin
                        state_q <= ST_PAR;
                    end
                end
                ST_PAR: begin
                    if (last_bit) begin
                        cnt_q <= '0;
                        if (accept) begin
                            msg_q   <= msg_in;
                            state_q <= ST_MSG;
                        end else begin
                            valid_q <= 1'b0;
                            state_q <= ST_IDLE;
                        end
                    end else begin
                        cnt_q  <= cnt_q + 3'd1;
                        done_q <= (cnt_q == LAST_BIT - 3'd1);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign code_valid = valid_q;
    assign busy       = valid_q;
    assign done       = done_q;
    assign codeword   = codeword_q;
endmodule
`default_nettype wire

// File: tb/tb_cyclic_encoder_7_4.sv
`default_nettype none
// ============================================================================
// tb_cyclic_encoder_7_4 : self-checking bench for the serial (7,4) encoder
// Revision: 1.0
// ============================================================================
module tb_cyclic_encoder_7_4;
    localparam logic [3:0] GPOLY = 4'b1011;

    typedef struct {
        logic [3:0] msg;
        logic [6:0] cw;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic [3:0] msg_in = 4'h0;
    logic       code_bit;
    logic       code_valid;
    logic       busy;
    logic       done;
    logic [6:0] codeword;

    int tests = 0;
    int fails = 0;

    cyclic_encoder_7_4 dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .msg_in     (msg_in),
        .code_bit   (code_bit),
        .code_valid (code_valid),
        .busy       (busy),
        .done       (done),
        .codeword   (codeword)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // GF(2) long division remainder of a 7-bit polynomial by g(x)
    function automatic logic [2:0] poly_mod(input logic [6:0] w);
        logic [6:0] r;
        logic [6:0] g;
        r = w;
        g = {3'b000, GPOLY};
        for (int b = 6; b >= 3; b--) begin
            if (r[b]) r = r ^ (g << (b - 3));
        end
        return r[2:0];
    endfunction

    function automatic logic [6:0] ref_encode(input logic [3:0] m);
        return {m, poly_mod({m, 3'b000})};
    endfunction

    // Called at a negedge with the DUT idle; leaves at the negedge after done.
    task automatic encode_word(input logic [3:0] m, input logic [6:0] exp,
                               input bit noise, input string name);
        logic [6:0] bits, vm, dm;
        logic       busy_bad;
        busy_bad = 1'b0;
        msg_in = m;
        start  = 1'b1;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            bits[6-i] = code_bit;
            vm[6-i]   = code_valid;
            dm[6-i]   = done;
            if (busy !== code_valid) busy_bad = 1'b1;
            if (noise && i < 6) begin
                start  = 1'($urandom_range(0, 1));
                msg_in = 4'($urandom);
            end else begin
                start = 1'b0;
            end
        end
        @(negedge clk);
        check({name, " bits"}, 32'(bits), 32'(exp));
        check({name, " valid"}, 32'(vm), 32'h7F);
        check({name, " done"}, 32'(dm), 32'h01);
        check({name, " busy"}, 32'(busy_bad), 32'h0);
        check({name, " codeword"}, 32'(codeword), 32'(exp));
        check({name, " idle"}, {29'h0, code_valid, done, code_bit}, 32'h0);
        check({name, " divisible"}, 32'(poly_mod(bits)), 32'h0);
    endtask

    initial begin
        vec_t vecs[4];
        logic [13:0] bits14, vm14, dm14;
        logic [3:0]  m;
        int          saw;

        vecs[0] = '{4'b1000, 7'b1000101};
        vecs[1] = '{4'b0001, 7'b0001011};
        vecs[2] = '{4'b1111, 7'b1111111};
        vecs[3] = '{4'b0000, 7'b0000000};

        // reset for 3 cycles with start held high: start must be ignored
        reset  = 1'b0;
        start  = 1'b1;
        msg_in = 4'b1111;
        repeat (3) @(negedge clk);
        check("reset outputs", {27'h0, code_bit, code_valid, busy, done, 1'b0}, 32'h0);
        check("reset codeword", 32'(codeword), 32'h0);
        reset = 1'b1;
        start = 1'b0;
        @(negedge clk);
        check("post-reset idle", {29'h0, code_valid, done, code_bit}, 32'h0);

        for (int i = 0; i < 4; i++) begin
            encode_word(vecs[i].msg, vecs[i].cw, 1'b0, $sformatf("table%0d", i));
        end

        for (int i = 0; i < 16; i++) begin
            m = 4'(i);
            encode_word(m, ref_encode(m), 1'b1, $sformatf("exh%0d", i));
        end

        for (int i = 0; i < 20; i++) begin
            m = 4'($urandom);
            encode_word(m, ref_encode(m), 1'b1, $sformatf("rnd%0d", i));
        end

        // back-to-back: second start lands in the done cycle of the first word
        msg_in = 4'b1000;
        start  = 1'b1;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            bits14[13-i] = code_bit;
            vm14[13-i]   = code_valid;
            dm14[i]      = done;
            if (i == 7) check("b2b first codeword", 32'(codeword), 32'h45);
            if (i == 6) begin
                start  = 1'b1;
                msg_in = 4'b0001;
            end else if ((i >= 1 && i <= 5) || (i >= 8 && i <= 12)) begin
                start  = 1'($urandom_range(0, 1));
                msg_in = 4'($urandom);
            end else begin
                start = 1'b0;
            end
        end
        @(negedge clk);
        check("b2b bits", 32'(bits14), 32'({7'b1000101, 7'b0001011}));
        check("b2b valid", 32'(vm14), 32'h3FFF);
        check("b2b done", 32'(dm14), 32'((1 << 6) | (1 << 13)));
        check("b2b second codeword", 32'(codeword), 32'h0B);
        check("b2b idle", 32'(code_valid), 32'h0);

        // reset during the third bit of 1111 aborts the word
        reset = 1'b0;
        @(negedge clk);
        reset  = 1'b1;
        msg_in = 4'b1111;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("abort third bit", {30'h0, code_valid, code_bit}, 32'h3);
        reset = 1'b0;
        @(negedge clk);
        check("abort outputs", {28'h0, code_bit, code_valid, busy, done}, 32'h0);
        check("abort codeword", 32'(codeword), 32'h0);
        reset = 1'b1;
        saw = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done || code_valid) saw++;
        end
        check("abort no resume", 32'(saw), 32'h0);
        check("abort codeword held", 32'(codeword), 32'h0);
        encode_word(4'b0001, 7'b0001011, 1'b0, "after abort");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/cyclic_encoder_7_4.md
CYCLIC_ENCODER_7_4 -- requirements
Module: cyclic_encoder_7_4

Interface
REQ-001 Parameter: GEN, default 3'b011, low-order coefficients {g2,g1,g0} of generator g(x)=x^3+g2x^2+g1x+g0 (default g(x)=x^3+x+1).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-low reset.
REQ-004 start  input  1  request to encode msg_in; sampled on rising edge.
REQ-005 msg_in  input  4  message u3..u0, u3 = highest-order coefficient.
REQ-006 code_bit  output  1  serial codeword bit, c6 first, c0 last.
REQ-007 code_valid  output  1  high while code_bit carries a codeword bit.
REQ-008 busy  output  1  high while a codeword is being emitted.
REQ-009 done  output  1  one-cycle pulse coincident with c0.
REQ-010 codeword  output  7  last complete codeword c6..c0; updated on the edge that ends the done cycle, held otherwise.

Function
REQ-011 The encoder SHALL be systematic: c6..c3 = u3..u0, c2..c0 = remainder of u(x)*x^3 mod g(x), c2 = x^2 coefficient.
REQ-012 States: IDLE, MSG (4 cycles), PAR (3 cycles); 3-bit bit counter 0..6.
REQ-013 IDLE: start=1 latches msg_in, clears parity register, and moves to MSG; start=0 stays in IDLE.
REQ-014 First bit latency: c6 appears on code_bit with code_valid=1 in the cycle after start is accepted.
REQ-015 code_valid SHALL stay high for exactly 7 consecutive cycles per accepted start.
REQ-016 MSG, per cycle with message bit u: fb = u ^ r2; r2 <= r1 ^ (g2&fb); r1 <= r0 ^ (g1&fb); r0 <= g0&fb.
REQ-017 PAR: emit r2, r1, r0 in order by shifting the parity register, with no feedback.
REQ-018 busy = code_valid.
REQ-019 done is high only in the c0 cycle.
REQ-020 start while busy and not in the c0 cycle SHALL be ignored, and msg_in is not sampled.
REQ-021 start in the c0 cycle SHALL be accepted, giving the next c6 in the immediately following cycle with no gap and no second done.
REQ-022 msg_in changes after acceptance SHALL NOT affect the codeword in flight.
REQ-023 When idle: code_bit=0, code_valid=0, done=0.

Reset
REQ-024 reset=0 at a rising edge SHALL force IDLE, counter=0, parity=0, code_bit=0, code_valid=0, busy=0, done=0, codeword=7'b0.
REQ-025 Reset mid-word SHALL abort the word; no done and no codeword update for it.
REQ-026 start asserted while reset=0 SHALL be ignored.
REQ-027 The first start is accepted only at an edge where reset=1.

Structure
REQ-028 The shared package SHALL hold N=7, K=4, DEFAULT_GEN=3'b011, and the state encoding IDLE/MSG/PAR.
REQ-029 The 3-bit parity LFSR SHALL be sub-module parity_lfsr_3 with ports clk, reset, clear, shift_in_en, shift_out_en, din, gen, dout.
REQ-030 The FSM and counter SHALL reside in cyclic_encoder_7_4.

Verification
REQ-031 Reset held 3 cycles, then msg_in=4'b1000 with start pulse -> serial 1,0,0,0,1,0,1; done on 7th bit; codeword=7'b1000101.
REQ-032 msg_in=4'b0001 -> 0001011.
REQ-033 msg_in=4'b1111 -> 1111111.
REQ-034 msg_in=4'b0000 -> 0000000 with code_valid high 7 cycles.
REQ-035 Back-to-back: start=1 with 4'b1000, then start=1 with 4'b0001 in the done cycle -> 14 contiguous valid bits 1000101 0001011, single done per word; start pulses mid-word ignored.
REQ-036 reset=0 during 3rd bit of 4'b1111 -> outputs 0 next edge, no done, codeword unchanged at 0; a following start with 4'b0001 -> 0001011.
REQ-037 Exhaustive: all 16 messages checked against a reference model (u(x)*x^3 mod g).
REQ-038 Exhaustive: every emitted codeword is divisible by g(x).
